// File: rtl/life_pkg.sv
// life_pkg -- shared types and constants for the life_engine cellular automaton.
//   life_state_t   : control FSM encoding (PAUSED / RUNNING / HALTED)
//   NBR_W          : width of a live-neighbour count (0..8)
//   CONWAY_BIRTH   : B3 birth mask
//   CONWAY_SURVIVE : S23 survive mask
//   count8()       : population count of an 8-bit neighbour vector
package life_pkg;

    typedef enum logic [1:0] {
        PAUSED  = 2'd0,
        RUNNING = 2'd1,
        HALTED  = 2'd2
    } life_state_t;

    localparam int          NBR_W          = 4;
    localparam logic [8:0]  CONWAY_BIRTH   = 9'b0_0000_1000;
    localparam logic [8:0]  CONWAY_SURVIVE = 9'b0_0000_1100;

    function automatic logic [NBR_W-1:0] count8(input logic [7:0] v);
        logic [NBR_W-1:0] n;
        n = '0;
        for (int i = 0; i < 8; i++) begin
            n = n + NBR_W'(v[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/life_cell_next.sv
// life_cell_next -- next-generation value of one cell under an outer-totalistic rule.
//   nbr          in  8  live/dead state of the eight surrounding cells
//   cur          in  1  current state of this cell
//   birth_mask   in  9  bit n: dead cell with n live neighbours becomes live
//   survive_mask in  9  bit n: live cell with n live neighbours stays live
//   nxt          out 1  cell state for the next generation (combinational)
module life_cell_next
    import life_pkg::*;
(
    input  logic [7:0] nbr,
    input  logic       cur,
    input  logic [8:0] birth_mask,
    input  logic [8:0] survive_mask,
    output logic       nxt
);

    logic [NBR_W-1:0] n;

    assign n   = count8(nbr);
    assign nxt = cur ? survive_mask[n] : birth_mask[n];

endmodule

// File: rtl/life_engine.sv
// life_engine -- W x H cellular-automaton engine with run/pause/step control.
//   clk, rst      clock; synchronous active-high reset
//   cmd_run       level: free-run at one generation per 2^TICK_DIV cycles
//   cmd_step      pulse: advance one generation while paused (held = every cycle)
//   cmd_load      pulse: copy init_cells into the grid, clear generation
//   init_cells    load / reset pattern, index W*y + x
//   birth_mask    dead cell with n neighbours is born when bit n set
//   survive_mask  live cell with n neighbours survives when bit n set
//   cells         current grid
//   generation    generations committed since last load/reset (wraps)
//   population    registered popcount of cells (one cycle behind)
//   stable        combinational: next generation equals cells
//   state         life_state_t FSM state
// Optional feature: define LIFE_AUTO_HALT_EN to stop in HALTED when a run-mode
// tick finds the grid stable. Without it HALTED is never entered.
module life_engine
    import life_pkg::*;
#(
    parameter int W        = 8,
    parameter int H        = 8,
    parameter int TICK_DIV = 23,
    parameter int GEN_W    = 16,
    parameter int WRAP     = 0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     cmd_run,
    input  logic                     cmd_step,
    input  logic                     cmd_load,
    input  logic [W*H-1:0]           init_cells,
    input  logic [8:0]               birth_mask,
    input  logic [8:0]               survive_mask,
    output logic [W*H-1:0]           cells,
    output logic [GEN_W-1:0]         generation,
    output logic [$clog2(W*H+1)-1:0] population,
    output logic                     stable,
    output life_state_t              state
);

    localparam int N  = W * H;
    localparam int PW = $clog2(N + 1);
    localparam int TW = (TICK_DIV > 0) ? TICK_DIV : 1;

    logic [N-1:0]  nxt;
    logic [PW-1:0] pop_c;
    logic [TW-1:0] tick_cnt;
    logic          tick;
    logic          halt_now;
    logic          go;
    logic          commit_vld;   // a step/tick was accepted last cycle; commit now

    // Per-cell neighbour wiring. Offsets k: 0..2 row below, 3/4 same row,
    // 5..7 row above. Off-grid neighbours either wrap or read dead.
    for (genvar y = 0; y < H; y++) begin : g_row
        for (genvar x = 0; x < W; x++) begin : g_col
            logic [7:0] nbr;
            for (genvar k = 0; k < 8; k++) begin : g_nbr
                localparam int DX = (k == 0 || k == 3 || k == 5) ? -1 :
                                    (k == 2 || k == 4 || k == 7) ?  1 : 0;
                localparam int DY = (k < 3) ? -1 : (k < 5) ? 0 : 1;
                localparam int NX = x + DX;
                localparam int NY = y + DY;
                localparam int ON = (NX >= 0 && NX < W && NY >= 0 && NY < H) ? 1 : 0;
                localparam int WX = (NX + W) % W;
                localparam int WY = (NY + H) % H;
                if (WRAP != 0 || ON != 0) begin : g_live
                    assign nbr[k] = cells[W*WY + WX];
                end else begin : g_dead
                    assign nbr[k] = 1'b0;
                end
            end
            life_cell_next u_cell (
                .nbr          (nbr),
                .cur          (cells[W*y + x]),
                .birth_mask   (birth_mask),
                .survive_mask (survive_mask),
                .nxt          (nxt[W*y + x])
            );
        end
    end

    assign stable = (nxt == cells);

    always_comb begin
        pop_c = '0;
        for (int i = 0; i < N; i++) begin
            pop_c = pop_c + PW'(cells[i]);
        end
    end

    assign tick = (state == RUNNING) && ((TICK_DIV == 0) || (tick_cnt == '1));

`ifdef LIFE_AUTO_HALT_EN
    assign halt_now = stable;
`else
    assign halt_now = 1'b0;
`endif

    // Request a commit for next cycle: step only while paused, tick only while
    // running and not halting on it.
    assign go = ((state == PAUSED) && cmd_step) || (tick && !halt_now);

    always_ff @(posedge clk) begin
        if (rst) begin
            cells      <= init_cells;
            generation <= '0;
            population <= '0;
            tick_cnt   <= '0;
            commit_vld <= 1'b0;
            state      <= PAUSED;
        end else begin
            population <= pop_c;
            if (cmd_load) begin
                // Load wins over any commit this cycle and drops any pending one.
                cells      <= init_cells;
                generation <= '0;
                tick_cnt   <= '0;
                commit_vld <= 1'b0;
                if (state == HALTED) state <= PAUSED;
            end else begin
                commit_vld <= go;
                if (commit_vld) begin
                    cells      <= nxt;
                    generation <= generation + 1'b1;
                end
                case (state)
                    PAUSED: begin
                        tick_cnt <= '0;
                        if (cmd_run) state <= RUNNING;
                    end
                    RUNNING: begin
                        if (!cmd_run) begin
                            state    <= PAUSED;
                            tick_cnt <= '0;
                        end else if (tick && halt_now) begin
                            state    <= HALTED;
                            tick_cnt <= '0;
                        end else begin
                            tick_cnt <= tick_cnt + 1'b1;
                        end
                    end
                    HALTED: begin
                        tick_cnt <= '0;
                        if (!cmd_run) state <= PAUSED;
                    end
                    default: begin
                        tick_cnt <= '0;
                        state    <= PAUSED;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_life_engine.sv
module tb_life_engine;
    import life_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        run_f = 1'b0, run_w = 1'b0;
    logic        cmd_step = 1'b0, cmd_load = 1'b0;
    logic [63:0] init_cells;
    logic [8:0]  bm, sm;

    logic [63:0] cells_f, cells_w;
    logic [2:0]  gen_f;
    logic [15:0] gen_w;
    logic [6:0]  pop_f, pop_w;
    logic        stable_f, stable_w;
    life_state_t st_f, st_w;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    // Bounded-edge grid, short generation counter, 4-cycle tick.
    life_engine #(.W(8), .H(8), .TICK_DIV(2), .GEN_W(3), .WRAP(0)) u_flat (
        .clk(clk), .rst(rst), .cmd_run(run_f), .cmd_step(cmd_step), .cmd_load(cmd_load),
        .init_cells(init_cells), .birth_mask(bm), .survive_mask(sm),
        .cells(cells_f), .generation(gen_f), .population(pop_f),
        .stable(stable_f), .state(st_f));

    // Torus grid, tick every cycle.
    life_engine #(.W(8), .H(8), .TICK_DIV(0), .GEN_W(16), .WRAP(1)) u_wrap (
        .clk(clk), .rst(rst), .cmd_run(run_w), .cmd_step(cmd_step), .cmd_load(cmd_load),
        .init_cells(init_cells), .birth_mask(bm), .survive_mask(sm),
        .cells(cells_w), .generation(gen_w), .population(pop_w),
        .stable(stable_w), .state(st_w));

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [63:0] pat);
        init_cells = pat;
        cmd_load   = 1'b1;
        cyc(1);
        cmd_load   = 1'b0;
    endtask

    // Reference rule: count the eight neighbours of every cell directly.
    function automatic logic [63:0] life_next(input logic [63:0] g, input logic [8:0] b,
                                              input logic [8:0] s, input bit wrap);
        logic [63:0] r;
        r = '0;
        for (int y = 0; y < 8; y++) begin
            for (int x = 0; x < 8; x++) begin
                int n;
                n = 0;
                for (int dy = -1; dy <= 1; dy++) begin
                    for (int dx = -1; dx <= 1; dx++) begin
                        int nx, ny;
                        if (dx == 0 && dy == 0) continue;
                        nx = x + dx;
                        ny = y + dy;
                        if (wrap) begin
                            nx = (nx + 8) % 8;
                            ny = (ny + 8) % 8;
                        end
                        if (nx >= 0 && nx < 8 && ny >= 0 && ny < 8) n += int'(g[8*ny + nx]);
                    end
                end
                r[8*y + x] = g[8*y + x] ? s[n] : b[n];
            end
        end
        return r;
    endfunction

    function automatic logic [63:0] life_gens(input logic [63:0] g, input logic [8:0] b,
                                              input logic [8:0] s, input bit wrap, input int k);
        logic [63:0] r;
        r = g;
        for (int i = 0; i < k; i++) r = life_next(r, b, s, wrap);
        return r;
    endfunction

    initial begin
        logic [63:0] blinker, vert, block, glider, pat, ef, ew, pf;
        int k;
        bit seen;

        blinker = '0; blinker[27] = 1'b1; blinker[28] = 1'b1; blinker[29] = 1'b1;
        vert    = '0; vert[20]    = 1'b1; vert[28]    = 1'b1; vert[36]    = 1'b1;
        block   = '0; block[27]   = 1'b1; block[28]   = 1'b1; block[35]   = 1'b1; block[36] = 1'b1;
        glider  = '0; glider[1] = 1'b1; glider[10] = 1'b1;
        glider[16] = 1'b1; glider[17] = 1'b1; glider[18] = 1'b1;

        // Reset state
        init_cells = blinker;
        bm = CONWAY_BIRTH;
        sm = CONWAY_SURVIVE;
        cyc(2);
        chk("rst_state_f", st_f, PAUSED);
        chk("rst_gen_f", gen_f, 0);
        chk("rst_pop_f", pop_f, 0);
        chk("rst_cells_f", cells_f, blinker);
        chk("rst_cells_w", cells_w, blinker);
        rst = 1'b0;
        cyc(1);
        chk("pop_after_rst", pop_f, 3);

        // Blinker single step
        cmd_step = 1'b1;
        cyc(1);
        cmd_step = 1'b0;
        chk("step_latency_gen", gen_f, 0);
        cyc(1);
        chk("blinker_cells_f", cells_f, vert);
        chk("blinker_cells_w", cells_w, vert);
        chk("blinker_gen_f", gen_f, 1);
        chk("blinker_stable", stable_f, 0);
        cyc(1);
        chk("blinker_pop", pop_f, 3);

        // All-zero masks kill everything
        bm = '0; sm = '0;
        pat = {$urandom, $urandom};
        load(pat);
        chk("zero_load_cells", cells_f, pat);
        chk("zero_load_gen", gen_f, 0);
        cmd_step = 1'b1; cyc(1); cmd_step = 1'b0; cyc(1);
        chk("zero_cells_f", cells_f, 0);
        chk("zero_cells_w", cells_w, 0);
        chk("zero_stable", stable_f, 1);
        cyc(1);
        chk("zero_pop", pop_f, 0);

        // Load and step together: load wins, no commit follows
        bm = CONWAY_BIRTH; sm = CONWAY_SURVIVE;
        pat = {$urandom, $urandom};
        init_cells = pat;
        cmd_load = 1'b1; cmd_step = 1'b1;
        cyc(1);
        cmd_load = 1'b0; cmd_step = 1'b0;
        cyc(1);
        chk("ldstep_cells_f", cells_f, pat);
        chk("ldstep_cells_w", cells_w, pat);
        chk("ldstep_gen_f", gen_f, 0);

        // Random rules and patterns, step held for k cycles
        for (int it = 0; it < 12; it++) begin
            pat = {$urandom, $urandom};
            bm  = 9'($urandom);
            sm  = 9'($urandom);
            k   = int'($urandom_range(1, 3));
            load(pat);
            cmd_step = 1'b1; cyc(k); cmd_step = 1'b0; cyc(1);
            ef = life_gens(pat, bm, sm, 1'b0, k);
            ew = life_gens(pat, bm, sm, 1'b1, k);
            pf = life_gens(pat, bm, sm, 1'b0, k - 1);
            chk($sformatf("rnd%0d_cells_f", it), cells_f, ef);
            chk($sformatf("rnd%0d_cells_w", it), cells_w, ew);
            chk($sformatf("rnd%0d_gen_f", it), gen_f, 3'(k));
            chk($sformatf("rnd%0d_gen_w", it), gen_w, 16'(k));
            chk($sformatf("rnd%0d_pop_lag", it), pop_f, $countones(pf));
            chk($sformatf("rnd%0d_stable_f", it), stable_f, life_next(ef, bm, sm, 1'b0) == ef);
            chk($sformatf("rnd%0d_stable_w", it), stable_w, life_next(ew, bm, sm, 1'b1) == ew);
            cyc(1);
            chk($sformatf("rnd%0d_pop", it), pop_f, $countones(ef));
        end

        // Generation counter wrap (3-bit vs 16-bit)
        bm = CONWAY_BIRTH; sm = CONWAY_SURVIVE;
        pat = {$urandom, $urandom};
        load(pat);
        cmd_step = 1'b1; cyc(9); cmd_step = 1'b0; cyc(1);
        chk("wrap_gen_f", gen_f, 1);
        chk("wrap_gen_w", gen_w, 9);
        chk("wrap_cells_f", cells_f, life_gens(pat, bm, sm, 1'b0, 9));
        chk("wrap_cells_w", cells_w, life_gens(pat, bm, sm, 1'b1, 9));

        // Run-mode tick rate: one generation every 4 cycles on u_flat
        load(blinker);
        run_f = 1'b1;
        cyc(5);
        chk("tick_state", st_f, RUNNING);
        chk("tick_gen0", gen_f, 0);
        cyc(1);
        chk("tick_gen1", gen_f, 1);
        chk("tick_cells1", cells_f, vert);
        cyc(3);
        chk("tick_gen1_hold", gen_f, 1);
        cyc(1);
        chk("tick_gen2", gen_f, 2);
        chk("tick_cells2", cells_f, blinker);
        run_f = 1'b0;
        cyc(1);
        chk("tick_pause", st_f, PAUSED);

        // Stable block under run
        load(block);
        run_f = 1'b1;
        cyc(6);
`ifdef LIFE_AUTO_HALT_EN
        chk("halt_state", st_f, HALTED);
        chk("halt_gen", gen_f, 0);
        chk("halt_cells", cells_f, block);
        cmd_step = 1'b1; cyc(1); cmd_step = 1'b0; cyc(1);
        chk("halt_step_ignored", gen_f, 0);
        run_f = 1'b0;
        cyc(1);
        chk("halt_release", st_f, PAUSED);
`else
        chk("block_state", st_f, RUNNING);
        chk("block_gen", gen_f, 1);
        chk("block_cells", cells_f, block);
        chk("block_stable", stable_f, 1);
        run_f = 1'b0;
        cyc(2);
        chk("block_pause", st_f, PAUSED);
`endif

        // Glider on the torus returns home after 32 generations
        load(glider);
        run_w = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            cyc(1);
            if (gen_w == 16'd30) seen = 1'b1;
        end
        chk("glider_reach_gen30", seen, 1);
        run_w = 1'b0;
        cyc(3);
        chk("glider_gen", gen_w, 32);
        chk("glider_cells", cells_w, glider);
        chk("glider_state", st_w, PAUSED);

        // Reset mid-run at generation 5
        load(blinker);
        run_w = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 50 && !seen; i++) begin
            cyc(1);
            if (gen_w == 16'd5) seen = 1'b1;
        end
        chk("midrst_reach_gen5", seen, 1);
        chk("midrst_running", st_w, RUNNING);
        rst = 1'b1;
        run_w = 1'b0;
        cyc(1);
        chk("midrst_state", st_w, PAUSED);
        chk("midrst_gen", gen_w, 0);
        chk("midrst_cells", cells_w, blinker);
        chk("midrst_pop", pop_w, 0);
        rst = 1'b0;
        cyc(1);
        chk("midrst_pop_after", pop_w, 3);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
